// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product with valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to add the is_signed port for two's-complement operands.
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             neg_in;

  // Signed mode runs the unsigned datapath on magnitudes and restores the sign at the end.
  always_comb begin
    a_mag  = A;
    b_mag  = B;
    neg_in = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    if (is_signed) begin
      if (A[WIDTH-1]) a_mag = ~A + 1'b1;
      if (B[WIDTH-1]) b_mag = ~B + 1'b1;
      neg_in = A[WIDTH-1] ^ B[WIDTH-1];
    end
`endif
  end

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    result   = neg ? (~acc_next + 1'b1) : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            neg    <= neg_in;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Last iteration: publish the final sum directly so out_valid lands WIDTH+1 edges after accept.
          if (cnt == CNT_W'(1)) begin
            product <= result;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH 8 (main), WIDTH 4 and WIDTH 16 instances.
module tb_seq_multiplier;

  logic clk;
  logic rst;
  logic out_ready;
`ifdef SEQ_MULT_SIGNED_EN
  logic sgn;
`endif

  logic        iv8, ir8, ov8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, ov4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv16, ir16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(sgn),
`endif
    .out_valid(ov8), .out_ready(out_ready), .product(p8), .busy(busy8));

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(sgn),
`endif
    .out_valid(ov4), .out_ready(out_ready), .product(p4), .busy(busy4));

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(sgn),
`endif
    .out_valid(ov16), .out_ready(out_ready), .product(p16), .busy(busy16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return ov8;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      4:       return ir4;
      16:      return ir16;
      default: return ir8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'd0, p4};
      16:      return p16;
      default: return {16'd0, p8};
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b);
    case (w)
      4:       begin iv4  = v; a4  = a[3:0]; b4  = b[3:0]; end
      16:      begin iv16 = v; a16 = a;      b16 = b;      end
      default: begin iv8  = v; a8  = a[7:0]; b8  = b[7:0]; end
    endcase
  endtask

  // One full transaction: accept, latency count, product, output handshake.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    drive(w, 1'b1, a, b);
`ifdef SEQ_MULT_SIGNED_EN
    sgn = s;
`else
    if (s) $display("note: signed vector %s skipped in unsigned build", tag);
`endif
    chk({tag, "_ir_idle"}, 64'(get_ir(w)), 64'd1);
    @(negedge clk);
    drive(w, 1'b0, ~a, ~b);
`ifdef SEQ_MULT_SIGNED_EN
    sgn = ~s;
`endif
    n = 1;
    chk({tag, "_busy"}, 64'(get_busy(w)), 64'd1);
    chk({tag, "_ir_calc"}, 64'(get_ir(w)), 64'd0);
    while (!get_ov(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(w + 1));
    chk({tag, "_prod"}, 64'(get_prod(w)), 64'(exp));
    chk({tag, "_ir_done"}, 64'(get_ir(w)), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(get_ov(w)), 64'd0);
    chk({tag, "_ir_back"}, 64'(get_ir(w)), 64'd1);
    chk({tag, "_prod_hold"}, 64'(get_prod(w)), 64'(exp));
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    out_ready = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    drive(8, 1'b0, 16'd0, 16'd0);
    drive(4, 1'b0, 16'd0, 16'd0);
    drive(16, 1'b0, 16'd0, 16'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ir", 64'(ir8), 64'd1);
    end
    chk("rst_ov", 64'(ov8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_prod", 64'(p8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ir", 64'(ir8), 64'd1);

    run_op(8, 16'd0, 16'd0, 1'b0, 32'h0000, "zero");
    run_op(8, 16'd13, 16'd10, 1'b0, 32'd130, "13x10");
    run_op(8, 16'd255, 16'd255, 1'b0, 32'hFE01, "max8");

    // Backpressure: product held, new operands refused while in DONE.
    @(negedge clk);
    drive(8, 1'b1, 16'd6, 16'd15);
    @(negedge clk);
    drive(8, 1'b0, 16'd0, 16'd0);
    n = 1;
    while (!ov8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", 64'(n), 64'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", 64'(ov8), 64'd1);
      chk("bp_prod", 64'(p8), 64'd90);
      chk("bp_ir", 64'(ir8), 64'd0);
      if (i >= 2) drive(8, 1'b1, 16'd1, 16'd1);
      @(negedge clk);
    end
    drive(8, 1'b0, 16'd0, 16'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ov_drop", 64'(ov8), 64'd0);
    chk("bp_no_accept", 64'(busy8), 64'd0);
    chk("bp_prod_hold", 64'(p8), 64'd90);

    // Reset during CALC aborts the operation.
    @(negedge clk);
    drive(8, 1'b1, 16'd9, 16'd2);
    @(negedge clk);
    drive(8, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ov", 64'(ov8), 64'd0);
    chk("abort_ir", 64'(ir8), 64'd1);
    chk("abort_prod", 64'(p8), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("abort_no_pulse", 64'(seen), 64'd0);
    run_op(8, 16'd9, 16'd2, 1'b0, 32'd18, "9x2");

    // Reset wins over a simultaneous in_valid.
    @(negedge clk);
    rst = 1'b1;
    drive(8, 1'b1, 16'd3, 16'd3);
    @(negedge clk);
    rst = 1'b0;
    drive(8, 1'b0, 16'd0, 16'd0);
    chk("rst_vs_iv_busy", 64'(busy8), 64'd0);
    chk("rst_vs_iv_ir", 64'(ir8), 64'd1);

    run_op(4, 16'hD, 16'hA, 1'b0, 32'h82, "w4_dxa");
    run_op(4, 16'hF, 16'hF, 1'b0, 32'hE1, "w4_max");
    run_op(16, 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "w16");

`ifdef SEQ_MULT_SIGNED_EN
    run_op(8, 16'h00FD, 16'h0005, 1'b1, 32'hFFF1, "s_m3x5");
    run_op(8, 16'h0080, 16'h0080, 1'b1, 32'h4000, "s_min2");
    run_op(8, 16'h00FD, 16'h0005, 1'b0, 32'h04F1, "u_fdx5");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
